// File: rtl/filtro_dac_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : filtro_dac_tx_if
// Brief    : Filter-controller handshake bundle for the DAC serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface filtro_dac_tx_if #(
  parameter int cant_bits = 25
);
  logic [cant_bits-1:0] in;
  logic                 inicio;
  logic                 ocupado;
  logic                 fin;

  modport master (
    output in,
    output inicio,
    input  ocupado,
    input  fin
  );

  modport slave (
    input  in,
    input  inicio,
    output ocupado,
    output fin
  );
endinterface
`default_nettype wire

// File: rtl/filtro_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : filtro_dac_tx
// Brief    : Converts a signed filter result to offset-binary and shifts it out
//            MSB-first in a 16-bit sync_n/sclk/sdo frame to an external DAC.
// Revision : 1.0 - initial release
// ============================================================================
module filtro_dac_tx #(
  parameter int cant_bits = 25,
  parameter int dac_bits  = 12,
  parameter int msb_pos   = 24,
  parameter int div       = 2
) (
  input  logic              clk,
  input  logic              rst,
  filtro_dac_tx_if.slave    bus,
  output logic              sclk,
  output logic              sync_n,
  output logic              sdo
);

  localparam int                c_DIV_W    = (div > 1) ? $clog2(div) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(div - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_END   = 2'd2
  } state_t;

  state_t               r_state;
  logic [15:0]          r_shift;
  logic [3:0]           r_bit;
  logic [c_DIV_W-1:0]   r_div;
  logic                 r_sclk;
  logic                 r_sync_n;
  logic                 r_sdo;
  logic                 r_ocupado;
  logic                 r_fin;

  logic [dac_bits-1:0]  w_code;
  logic [15:0]          w_frame;
  logic                 w_div_last;

  // Inverting the sign bit of the truncated two's-complement value gives offset binary.
  assign w_code     = {~bus.in[msb_pos], bus.in[msb_pos-1 -: dac_bits-1]};
  assign w_frame    = 16'(w_code);
  assign w_div_last = (r_div == c_DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit     <= '0;
      r_div     <= '0;
      r_sclk    <= 1'b1;
      r_sync_n  <= 1'b1;
      r_sdo     <= 1'b0;
      r_ocupado <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.inicio) begin
            r_shift   <= w_frame;
            r_sync_n  <= 1'b0;
            r_sdo     <= w_frame[15];
            r_ocupado <= 1'b1;
            r_bit     <= 4'd15;
            r_div     <= '0;
            r_state   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_div_last) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            // Data only moves on the rising toggle so sdo is settled around the falling one.
            if (!r_sclk) begin
              if (r_bit == 4'd0) begin
                r_sync_n <= 1'b1;
                r_sdo    <= 1'b0;
                r_state  <= S_END;
              end else begin
                r_shift <= {r_shift[14:0], 1'b0};
                r_sdo   <= r_shift[14];
                r_bit   <= r_bit - 4'd1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_END: begin
          if (w_div_last) begin
            r_div     <= '0;
            r_ocupado <= 1'b0;
            r_fin     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sclk        = r_sclk;
  assign sync_n      = r_sync_n;
  assign sdo         = r_sdo;
  assign bus.ocupado = r_ocupado;
  assign bus.fin     = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_filtro_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_filtro_dac_tx
// Brief    : Self-checking bench for filtro_dac_tx at div = 2, 1 and 5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filtro_dac_tx;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [24:0]     din   [NDUT];
  logic            start [NDUT];
  logic [NDUT-1:0] sclk_w, sync_w, sdo_w, ocup_w, fin_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Reference: drop the 13 LSBs (floor), then shift signed range -2048..2047 up by 2048.
  function automatic logic [15:0] exp_frame(input logic [24:0] v);
    int s;
    int t;
    s = int'($signed(v));
    t = s >>> 13;
    return 16'(t + 2048);
  endfunction

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int D = (k == 0) ? 2 : ((k == 1) ? 1 : 5);

    filtro_dac_tx_if #(.cant_bits(25)) bus ();
    assign bus.in     = din[k];
    assign bus.inicio = start[k];
    assign ocup_w[k]  = bus.ocupado;
    assign fin_w[k]   = bus.fin;

    filtro_dac_tx #(
      .cant_bits (25),
      .dac_bits  (12),
      .msb_pos   (24),
      .div       (D)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .sclk   (sclk_w[k]),
      .sync_n (sync_w[k]),
      .sdo    (sdo_w[k])
    );

    logic [15:0] sh      = '0;
    int          falls   = 0;
    int          occ     = 0;
    int          fin_cnt = 0;
    int          last_f  = 0;
    int          per_min = 1 << 30;
    int          per_max = 0;
    logic        p_sclk  = 1'b1;
    logic        p_sync  = 1'b1;
    logic        p_occ   = 1'b0;
    logic [15:0] frames    [$];
    int          nfalls    [$];
    int          occ_q     [$];
    int          fin_cyc   [$];
    int          start_cyc [$];

    always @(negedge clk) begin
      if (!rst) begin
        p_sclk = 1'b1;
        p_sync = 1'b1;
        p_occ  = 1'b0;
        occ    = 0;
        falls  = 0;
      end else begin
        if (p_sync && !sync_w[k]) begin
          sh    = '0;
          falls = 0;
          start_cyc.push_back(cyc);
        end
        if (!sync_w[k] && p_sclk && !sclk_w[k]) begin
          sh = {sh[14:0], sdo_w[k]};
          falls++;
          if (falls > 1) begin
            if (cyc - last_f < per_min) per_min = cyc - last_f;
            if (cyc - last_f > per_max) per_max = cyc - last_f;
          end
          last_f = cyc;
        end
        if (!p_sync && sync_w[k]) begin
          frames.push_back(sh);
          nfalls.push_back(falls);
        end
        if (ocup_w[k]) occ++;
        else if (p_occ) begin
          occ_q.push_back(occ);
          occ = 0;
        end
        if (fin_w[k]) begin
          fin_cnt++;
          fin_cyc.push_back(cyc);
        end
        p_sclk = sclk_w[k];
        p_sync = sync_w[k];
        p_occ  = ocup_w[k];
      end
    end

    task automatic send(input logic [24:0] v);
      @(negedge clk);
      din[k]   = v;
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
    endtask

    task automatic wait_fin(input int target, input int budget);
      int n;
      n = 0;
      while (fin_cnt < target && n < budget) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("fin_timeout_div%0d", D), 32'(fin_cnt >= target), 32'd1);
    endtask

    task automatic frame_chk(input string tag, input logic [24:0] v);
      int target;
      target = fin_cnt + 1;
      send(v);
      wait_fin(target, 40 * D + 20);
      repeat (4) @(negedge clk);
      chk({tag, "_frame"},   32'(frames[$]), 32'(exp_frame(v)));
      chk({tag, "_falls"},   32'(nfalls[$]), 32'd16);
      chk({tag, "_ocupado"}, 32'(occ_q[$]),  32'(33 * D));
      chk({tag, "_fincnt"},  32'(fin_cnt),   32'(target));
      chk({tag, "_permin"},  32'(per_min),   32'(2 * D));
      chk({tag, "_permax"},  32'(per_max),   32'(2 * D));
    endtask
  end

  initial begin
    logic [24:0] vals [3];
    logic [24:0] v1, v2;
    int nf, fc, ns, fi, n;

    for (int k = 0; k < NDUT; k++) begin
      din[k]   = '0;
      start[k] = 1'b0;
    end

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk",    32'(sclk_w[0]), 32'd1);
    chk("rst_sync_n",  32'(sync_w[0]), 32'd1);
    chk("rst_sdo",     32'(sdo_w[0]),  32'd0);
    chk("rst_ocupado", 32'(ocup_w[0]), 32'd0);
    chk("rst_fin",     32'(fin_w[0]),  32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic and boundary codes
    g_dut[0].frame_chk("s1_zero",   25'h0000000);
    g_dut[0].frame_chk("s2_maxpos", 25'h0FFFFFF);
    g_dut[0].frame_chk("s2_minneg", 25'h1000000);
    g_dut[0].frame_chk("s2_minus1", 25'h1FFFFFF);
    for (int i = 0; i < 6; i++) g_dut[0].frame_chk("s2_rand", 25'($urandom));

    // Start while busy is ignored
    v1 = 25'($urandom);
    v2 = ~v1;
    nf = g_dut[0].frames.size();
    fc = g_dut[0].fin_cnt;
    @(negedge clk); din[0] = v1; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (9) @(negedge clk);
    din[0] = v2; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    g_dut[0].wait_fin(fc + 1, 120);
    repeat (80) @(negedge clk);
    chk("s3_nframes", 32'(g_dut[0].frames.size()), 32'(nf + 1));
    chk("s3_frame",   32'(g_dut[0].frames[$]),     32'(exp_frame(v1)));
    chk("s3_fincnt",  32'(g_dut[0].fin_cnt),       32'(fc + 1));

    // inicio held high: back-to-back frames
    for (int i = 0; i < 3; i++) vals[i] = 25'($urandom);
    nf = g_dut[0].frames.size();
    fc = g_dut[0].fin_cnt;
    ns = g_dut[0].start_cyc.size();
    fi = g_dut[0].fin_cyc.size();
    @(negedge clk); din[0] = vals[0]; start[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!fin_w[0] && n < 120);
      chk("s4_fin_seen", 32'(fin_w[0]), 32'd1);
      if (i < 2) din[0] = vals[i+1];
      else       start[0] = 1'b0;
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("s4_frame%0d", i), 32'(g_dut[0].frames[nf+i]), 32'(exp_frame(vals[i])));
    for (int i = 0; i < 2; i++)
      chk($sformatf("s4_gap%0d", i), 32'(g_dut[0].start_cyc[ns+i+1]), 32'(g_dut[0].fin_cyc[fi+i] + 1));
    chk("s4_fincnt", 32'(g_dut[0].fin_cnt), 32'(fc + 3));

    // Asynchronous reset mid-frame
    nf = g_dut[0].frames.size();
    fc = g_dut[0].fin_cnt;
    g_dut[0].send(25'($urandom));
    n = 0;
    while (g_dut[0].falls < 7 && n < 120) begin
      @(posedge clk);
      n++;
    end
    chk("s5_reach7", 32'(g_dut[0].falls >= 7), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("s5_sclk",    32'(sclk_w[0]), 32'd1);
    chk("s5_sync_n",  32'(sync_w[0]), 32'd1);
    chk("s5_sdo",     32'(sdo_w[0]),  32'd0);
    chk("s5_ocupado", 32'(ocup_w[0]), 32'd0);
    chk("s5_fin",     32'(fin_w[0]),  32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("s5_nofin",    32'(g_dut[0].fin_cnt),       32'(fc));
    chk("s5_noframe",  32'(g_dut[0].frames.size()), 32'(nf));
    g_dut[0].frame_chk("s5_after", 25'($urandom));

    // Other divider builds
    g_dut[1].frame_chk("s6_div1_zero", 25'h0000000);
    g_dut[1].frame_chk("s6_div1_rand", 25'($urandom));
    g_dut[2].frame_chk("s6_div5_zero", 25'h0000000);
    g_dut[2].frame_chk("s6_div5_rand", 25'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
